// File: rtl/cv32e40p_regfile_multiport_if.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_regfile_multiport_if
// Purpose  : Read/write/reservation port bundle for the multiport register file.
// Revision : 1.0 - initial release
// ============================================================================
interface cv32e40p_regfile_multiport_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3,
  parameter int NUM_WPORTS = 2
) ();
  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr_i;
  logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata_o;
  logic [NUM_RPORTS-1:0]                 rbusy_o;
  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr_i;
  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_WPORTS-1:0]                 we_i;
  logic                                  rsv_valid_i;
  logic [ADDR_WIDTH-1:0]                 rsv_addr_i;
  logic                                  wcollision_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, rsv_valid_i, rsv_addr_i,
    input  rdata_o, rbusy_o, wcollision_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, rsv_valid_i, rsv_addr_i,
    output rdata_o, rbusy_o, wcollision_o
  );
endinterface
`default_nettype wire

// File: rtl/cv32e40p_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_regfile_multiport
// Purpose  : Multiport integer/FP register file with write bypass and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_regfile_multiport #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3,
  parameter int NUM_WPORTS = 2,
  parameter int FPU        = 0,
  parameter int PULP_ZFINX = 0,
  parameter int BYPASS     = 1
) (
  input wire clk_int,
  input wire rst_n,
  cv32e40p_regfile_multiport_if.slave bus
);

  localparam int                  c_NUM_WORDS = (FPU != 0 && PULP_ZFINX == 0) ? 64 : 32;
  localparam logic [ADDR_WIDTH:0] c_LIMIT     = (ADDR_WIDTH+1)'(c_NUM_WORDS);

  // Word 0 is hardwired to zero, so storage starts at index 1
  logic [DATA_WIDTH-1:0] r_mem [1:c_NUM_WORDS-1];
  logic [c_NUM_WORDS-1:1] r_busy;
  logic                   r_wcollision;

  logic [DATA_WIDTH-1:0]                 w_wdata [1:c_NUM_WORDS-1];
  logic [c_NUM_WORDS-1:1]                w_we;
  logic [c_NUM_WORDS-1:1]                w_rsv;
  logic                                  w_collision;
  logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] w_rdata;
  logic [NUM_RPORTS-1:0]                 w_rbusy;

  function automatic logic f_writable(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < c_LIMIT);
  endfunction

  // Per-word write decode; later ports overwrite earlier ones so the highest index wins
  always_comb begin
    w_we  = '0;
    w_rsv = '0;
    for (int w = 1; w < c_NUM_WORDS; w++) begin
      w_wdata[w] = '0;
      w_rsv[w]   = bus.rsv_valid_i && (bus.rsv_addr_i == ADDR_WIDTH'(w));
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (bus.we_i[p] && (bus.waddr_i[p] == ADDR_WIDTH'(w))) begin
          w_we[w]    = 1'b1;
          w_wdata[w] = bus.wdata_i[p];
        end
      end
    end
  end

  always_comb begin
    w_collision = 1'b0;
    for (int i = 0; i < NUM_WPORTS; i++) begin
      for (int j = i + 1; j < NUM_WPORTS; j++) begin
        if (bus.we_i[i] && bus.we_i[j] && (bus.waddr_i[i] == bus.waddr_i[j]) &&
            f_writable(bus.waddr_i[i])) begin
          w_collision = 1'b1;
        end
      end
    end
  end

  // Busy flags are never forwarded; only read data sees same-cycle writes
  always_comb begin
    for (int p = 0; p < NUM_RPORTS; p++) begin
      w_rdata[p] = '0;
      w_rbusy[p] = 1'b0;
      for (int w = 1; w < c_NUM_WORDS; w++) begin
        if (bus.raddr_i[p] == ADDR_WIDTH'(w)) begin
          w_rdata[p] = r_mem[w];
          w_rbusy[p] = r_busy[w];
        end
      end
      if (BYPASS != 0 && f_writable(bus.raddr_i[p])) begin
        for (int q = 0; q < NUM_WPORTS; q++) begin
          if (bus.we_i[q] && (bus.waddr_i[q] == bus.raddr_i[p])) begin
            w_rdata[p] = bus.wdata_i[q];
          end
        end
      end
    end
  end

  // Reservation has priority over a same-cycle write when updating the busy flag
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 1; w < c_NUM_WORDS; w++) begin
        r_mem[w] <= '0;
      end
      r_busy       <= '0;
      r_wcollision <= 1'b0;
    end else begin
      for (int w = 1; w < c_NUM_WORDS; w++) begin
        if (w_we[w]) begin
          r_mem[w] <= w_wdata[w];
        end
        if (w_rsv[w]) begin
          r_busy[w] <= 1'b1;
        end else if (w_we[w]) begin
          r_busy[w] <= 1'b0;
        end
      end
      r_wcollision <= w_collision;
    end
  end

  assign bus.rdata_o      = w_rdata;
  assign bus.rbusy_o      = w_rbusy;
  assign bus.wcollision_o = r_wcollision;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_regfile_multiport
// Purpose  : Directed self-checking bench for the multiport register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_regfile_multiport;

  logic clk_int = 1'b0;
  logic rst_n   = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_int = ~clk_int;

  // if0: default integer file; if1: FP bank, no bypass; if2: FP bank suppressed by Zfinx
  cv32e40p_regfile_multiport_if #(.ADDR_WIDTH(5)) if0 ();
  cv32e40p_regfile_multiport_if #(.ADDR_WIDTH(6)) if1 ();
  cv32e40p_regfile_multiport_if #(.ADDR_WIDTH(6)) if2 ();

  cv32e40p_regfile_multiport #(.ADDR_WIDTH(5)) u_dut0 (
    .clk_int (clk_int), .rst_n (rst_n), .bus (if0.slave)
  );
  cv32e40p_regfile_multiport #(.ADDR_WIDTH(6), .FPU(1), .BYPASS(0)) u_dut1 (
    .clk_int (clk_int), .rst_n (rst_n), .bus (if1.slave)
  );
  cv32e40p_regfile_multiport #(.ADDR_WIDTH(6), .FPU(1), .PULP_ZFINX(1)) u_dut2 (
    .clk_int (clk_int), .rst_n (rst_n), .bus (if2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  task automatic idle();
    if0.we_i = '0; if0.rsv_valid_i = 1'b0; if0.rsv_addr_i = '0;
    if1.we_i = '0; if1.rsv_valid_i = 1'b0; if1.rsv_addr_i = '0;
    if2.we_i = '0; if2.rsv_valid_i = 1'b0; if2.rsv_addr_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    if0.raddr_i = '0; if0.waddr_i = '0; if0.wdata_i = '0;
    if1.raddr_i = '0; if1.waddr_i = '0; if1.wdata_i = '0;
    if2.raddr_i = '0; if2.waddr_i = '0; if2.wdata_i = '0;
    idle();

    // Reset state
    if0.raddr_i[0] = 5'd5;
    #2;
    chk("rst_rdata", if0.rdata_o[0], 32'h0);
    chk("rst_rbusy", 32'(if0.rbusy_o[0]), 32'h0);
    chk("rst_wcoll", 32'(if0.wcollision_o), 32'h0);
    #15 rst_n = 1'b1;
    tick();

    // Write x5 on port 0, read on port 1 (bypass same cycle, stored next cycle)
    if0.we_i[0] = 1'b1; if0.waddr_i[0] = 5'd5; if0.wdata_i[0] = 32'hDEADBEEF;
    if0.raddr_i[1] = 5'd5;
    if1.we_i[0] = 1'b1; if1.waddr_i[0] = 6'd5; if1.wdata_i[0] = 32'hDEADBEEF;
    if1.raddr_i[1] = 6'd5;
    #1;
    chk("bypass_x5", if0.rdata_o[1], 32'hDEADBEEF);
    chk("nobypass_x5", if1.rdata_o[1], 32'h0);
    tick();
    idle();
    #1;
    chk("stored_x5", if0.rdata_o[1], 32'hDEADBEEF);
    chk("stored_x5_nb", if1.rdata_o[1], 32'hDEADBEEF);

    // Two ports write x7: highest port wins, collision pulses one cycle
    if0.we_i = 2'b11; if0.waddr_i[0] = 5'd7; if0.waddr_i[1] = 5'd7;
    if0.wdata_i[0] = 32'h11; if0.wdata_i[1] = 32'h22;
    if0.raddr_i[0] = 5'd7;
    #1;
    chk("bypass_x7_hi", if0.rdata_o[0], 32'h22);
    chk("wcoll_pre", 32'(if0.wcollision_o), 32'h0);
    tick();
    idle();
    #1;
    chk("x7_hi_wins", if0.rdata_o[0], 32'h22);
    chk("wcoll_pulse", 32'(if0.wcollision_o), 32'h1);
    tick();
    chk("wcoll_clear", 32'(if0.wcollision_o), 32'h0);

    // Same collision on x0: no store, no collision
    if0.we_i = 2'b11; if0.waddr_i[0] = 5'd0; if0.waddr_i[1] = 5'd0;
    if0.raddr_i[0] = 5'd0;
    #1;
    chk("x0_no_bypass", if0.rdata_o[0], 32'h0);
    tick();
    idle();
    #1;
    chk("x0_reads0", if0.rdata_o[0], 32'h0);
    chk("x0_no_wcoll", 32'(if0.wcollision_o), 32'h0);

    // Distinct addresses on both ports: both stored, no collision
    if0.we_i = 2'b11; if0.waddr_i[0] = 5'd10; if0.waddr_i[1] = 5'd11;
    if0.wdata_i[0] = 32'hA0A0; if0.wdata_i[1] = 32'hB1B1;
    tick();
    idle();
    if0.raddr_i[0] = 5'd10; if0.raddr_i[1] = 5'd11;
    #1;
    chk("dual_x10", if0.rdata_o[0], 32'hA0A0);
    chk("dual_x11", if0.rdata_o[1], 32'hB1B1);
    chk("dual_no_wcoll", 32'(if0.wcollision_o), 32'h0);

    // Reserve x9, hold busy, clear on write
    if0.rsv_valid_i = 1'b1; if0.rsv_addr_i = 5'd9; if0.raddr_i[2] = 5'd9;
    #1;
    chk("rsv_not_yet", 32'(if0.rbusy_o[2]), 32'h0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("x9_busy", 32'(if0.rbusy_o[2]), 32'h1);
      if (i < 3) tick();
    end
    if0.we_i[1] = 1'b1; if0.waddr_i[1] = 5'd9; if0.wdata_i[1] = 32'h5;
    #1;
    chk("busy_not_bypassed", 32'(if0.rbusy_o[2]), 32'h1);
    tick();
    idle();
    #1;
    chk("x9_freed", 32'(if0.rbusy_o[2]), 32'h0);
    chk("x9_data", if0.rdata_o[2], 32'h5);

    // Reservation of x0 ignored
    if0.rsv_valid_i = 1'b1; if0.rsv_addr_i = 5'd0; if0.raddr_i[2] = 5'd0;
    tick();
    idle();
    chk("x0_never_busy", 32'(if0.rbusy_o[2]), 32'h0);

    // Reserve and write x12 together: busy stays set, data taken
    if0.rsv_valid_i = 1'b1; if0.rsv_addr_i = 5'd12;
    if0.we_i[0] = 1'b1; if0.waddr_i[0] = 5'd12; if0.wdata_i[0] = 32'hA;
    if0.raddr_i[0] = 5'd12;
    tick();
    idle();
    #1;
    chk("x12_busy", 32'(if0.rbusy_o[0]), 32'h1);
    chk("x12_data", if0.rdata_o[0], 32'hA);

    // FP bank: f0 is writable; Zfinx variant ignores it and reports not busy
    if1.we_i = 2'b11; if1.waddr_i[0] = 6'd32; if1.wdata_i[0] = 32'h3F800000;
    if1.waddr_i[1] = 6'd0; if1.wdata_i[1] = 32'h1234;
    if1.raddr_i[0] = 6'd32; if1.raddr_i[1] = 6'd0;
    if2.we_i[0] = 1'b1; if2.waddr_i[0] = 6'd32; if2.wdata_i[0] = 32'h3F800000;
    if2.raddr_i[0] = 6'd32;
    if2.rsv_valid_i = 1'b1; if2.rsv_addr_i = 6'd40; if2.raddr_i[1] = 6'd40;
    #1;
    chk("zfinx_no_bypass", if2.rdata_o[0], 32'h0);
    tick();
    idle();
    #1;
    chk("fpu_f0", if1.rdata_o[0], 32'h3F800000);
    chk("fpu_x0", if1.rdata_o[1], 32'h0);
    chk("zfinx_f0", if2.rdata_o[0], 32'h0);
    chk("zfinx_oor_busy", 32'(if2.rbusy_o[1]), 32'h0);
    chk("zfinx_wcoll", 32'(if2.wcollision_o), 32'h0);

    // Fill all integer registers, reserve x3, then async reset mid-cycle
    for (int w = 1; w < 32; w++) begin
      if0.we_i[0] = 1'b1; if0.waddr_i[0] = 5'(w); if0.wdata_i[0] = 32'h100 + 32'(w);
      tick();
    end
    idle();
    if0.rsv_valid_i = 1'b1; if0.rsv_addr_i = 5'd3;
    tick();
    idle();
    if0.raddr_i[0] = 5'd3; if0.raddr_i[1] = 5'd31; if0.raddr_i[2] = 5'd1;
    #1;
    chk("fill_x3", if0.rdata_o[0], 32'h103);
    chk("fill_x31", if0.rdata_o[1], 32'h11F);
    chk("fill_x3_busy", 32'(if0.rbusy_o[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_x3", if0.rdata_o[0], 32'h0);
    chk("arst_x31", if0.rdata_o[1], 32'h0);
    chk("arst_x1", if0.rdata_o[2], 32'h0);
    chk("arst_busy", 32'(if0.rbusy_o[0]), 32'h0);
    chk("arst_f0", if1.rdata_o[0], 32'h0);
    // In-flight write and reservation during reset are discarded
    if0.we_i[0] = 1'b1; if0.waddr_i[0] = 5'd3; if0.wdata_i[0] = 32'hBAD;
    if0.rsv_valid_i = 1'b1; if0.rsv_addr_i = 5'd3;
    tick();
    idle();
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_x3", if0.rdata_o[0], 32'h0);
    chk("post_rst_busy", 32'(if0.rbusy_o[0]), 32'h0);
    if0.we_i[1] = 1'b1; if0.waddr_i[1] = 5'd4; if0.wdata_i[1] = 32'h44;
    if0.raddr_i[2] = 5'd4;
    tick();
    idle();
    #1;
    chk("post_rst_x4", if0.rdata_o[2], 32'h44);
    chk("post_rst_x31", if0.rdata_o[1], 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e40p_regfile_multiport.md
CV32E40P_REGFILE_MULTIPORT -- requirements
Module: cv32e40p_regfile_multiport

Interface
REQ-001 Parameter ADDR_WIDTH, default 5; register address width; SHALL be 6 when FPU=1 and PULP_ZFINX=0.
REQ-002 Parameter DATA_WIDTH, default 32; register width.
REQ-003 Parameter NUM_RPORTS, default 3, range 1..4; number of read ports.
REQ-004 Parameter NUM_WPORTS, default 2, range 1..3; number of write ports.
REQ-005 Parameter FPU, default 0; 1 adds 32 FP registers at addresses 32..63.
REQ-006 Parameter PULP_ZFINX, default 0; 1 suppresses the FP bank even when FPU=1.
REQ-007 Parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding.
REQ-008 clk_int  in  1  clock; all state updates on its rising edge.
REQ-009 rst_n  in  1  reset; asynchronous, active-low.
REQ-010 raddr_i  in  NUM_RPORTS x ADDR_WIDTH  read addresses.
REQ-011 rdata_o  out  NUM_RPORTS x DATA_WIDTH  read data, combinational.
REQ-012 rbusy_o  out  NUM_RPORTS  scoreboard busy bit of each read address, combinational.
REQ-013 waddr_i, wdata_i, we_i  in  NUM_WPORTS x (ADDR_WIDTH, DATA_WIDTH, 1)  write ports.
REQ-014 rsv_valid_i, rsv_addr_i  in  1, ADDR_WIDTH  scoreboard reservation for a long-latency destination.
REQ-015 wcollision_o  out  1  registered pulse: two or more enabled write ports targeted the same writable address.

Function
REQ-016 Register count SHALL be 64 when FPU=1 and PULP_ZFINX=0, else 32; address bit 5 selects the FP bank.
REQ-017 Address 0 (x0) SHALL read 0, SHALL never be written, SHALL never be busy; FP address 32 (f0) SHALL be an ordinary writable register.
REQ-018 An enabled write SHALL update the addressed register on the rising edge of clk_int; the new value SHALL be visible on rdata_o from the following cycle.
REQ-019 When several enabled write ports target the same address in one cycle, the highest-indexed port SHALL win.
REQ-020 wcollision_o SHALL assert for exactly one cycle, the cycle after such a conflict on a nonzero address; it SHALL be 0 otherwise.
REQ-021 BYPASS=1: a read whose address equals an enabled same-cycle write address (nonzero) SHALL return that write's wdata_i, highest port winning; BYPASS=0: the read SHALL return the stored value.
REQ-022 Scoreboard: one busy bit per register; rsv_valid_i with a nonzero rsv_addr_i SHALL set the bit on the next edge.
REQ-023 An enabled write to a busy address SHALL clear its busy bit on the same edge.
REQ-024 A reservation and a write to the same address in the same cycle SHALL leave the bit set; the reservation wins and the register takes the write data.
REQ-025 A reservation of an already-busy address SHALL keep it busy; a reservation of address 0 SHALL be ignored.
REQ-026 rbusy_o[p] SHALL reflect the stored busy bit for raddr_i[p] and SHALL NOT be bypassed.
REQ-027 Out-of-range addresses SHALL read 0, SHALL report not busy, and SHALL have writes ignored (FP addresses when the FP bank is absent).

Reset
REQ-028 While rst_n=0, all registers SHALL be 0, all busy bits 0, and wcollision_o 0, independent of clk_int.
REQ-029 Reset asserted mid-operation SHALL discard in-flight writes and reservations; the first edge after release SHALL behave normally.

Verification
REQ-030 Write x5=0xDEADBEEF on port 0, read port 1 addr 5 next cycle -> 0xDEADBEEF; with BYPASS=1, same-cycle read also -> 0xDEADBEEF.
REQ-031 Ports 0 and 1 both write x7 (0x11, 0x22) -> x7=0x22 next cycle; wcollision_o=1 for exactly one cycle; same test on x0 -> x0 reads 0 and wcollision_o=0.
REQ-032 Reserve x9, then 3 idle cycles -> rbusy_o=1 for addr 9 throughout; write x9=0x5 -> busy=0 next cycle, data 0x5.
REQ-033 Reserve x12 and write x12=0xA in the same cycle -> busy stays 1, x12 reads 0xA.
REQ-034 FPU=1, PULP_ZFINX=0: write addr 32=0x3F800000 and x0 -> addr 32 reads 0x3F800000, x0 reads 0; PULP_ZFINX=1: addr 32 write ignored, reads 0.
REQ-035 Fill all registers, reserve x3, assert rst_n=0 asynchronously mid-cycle -> all reads 0 and all busy bits 0 immediately; writes after release behave per REQ-018.
